// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode encoding and request bundle.
package alu_pkg;
    localparam int ALU_W = 32;
    localparam int ALU_CTRL_W = 4;
    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_XOR = 4'b0100
    } alu_op_e;
    // op kept as raw bits so unsupported codes can still flow through
    typedef struct packed {
        logic [ALU_W-1:0]      in1;
        logic [ALU_W-1:0]      in2;
        logic [ALU_CTRL_W-1:0] op;
    } alu_req_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit AND/OR/ADD/SUB/XOR; other opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]      in1_i,
    input  logic [ALU_W-1:0]      in2_i,
    input  logic [ALU_CTRL_W-1:0] op_i,
    output logic [ALU_W-1:0]      result_o,
    output logic                  zero_o
);
    assign result_o = op_i == ALU_AND ? in1_i & in2_i :
                      op_i == ALU_OR  ? in1_i | in2_i :
                      op_i == ALU_ADD ? in1_i + in2_i :
                      op_i == ALU_SUB ? in1_i - in2_i :
                      op_i == ALU_XOR ? in1_i ^ in2_i : '0;
    assign zero_o = (op_i == ALU_SUB) && (in1_i == in2_i);
endmodule

// File: rtl/alu_share_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant; pointer moves past the winner.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o
);
    logic [PW-1:0] rr_ptr_q, rr_ptr_d, j;
    // descending scan so the closest requester after the pointer wins
    always_comb begin
        grant_o = '0;
        rr_ptr_d = rr_ptr_q;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(rr_ptr_q) + k) % N);
            if (en_i && req_i[j]) begin
                grant_o = '0;
                grant_o[j] = 1'b1;
                rr_ptr_d = (int'(j) == N - 1) ? '0 : j + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else if (en_i && |req_i) rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NUM_REQ requesters
// with a single registered, id-tagged response slot.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ALU_W-1:0]      req_in1,
    input  logic [NUM_REQ*ALU_W-1:0]      req_in2,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_op,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [ALU_W-1:0]              rsp_result,
    output logic                          rsp_zero
);
    logic             slot_free, rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
    alu_req_t         sel;
    assign slot_free = !rsp_valid_q || rsp_ready;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_valid),
        .en_i   (slot_free && !rst),
        .grant_o(req_ready)
    );
    always_comb begin
        sel = '0;
        rsp_id_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel.in1 = req_in1[ALU_W*i +: ALU_W];
                sel.in2 = req_in2[ALU_W*i +: ALU_W];
                sel.op = req_op[ALU_CTRL_W*i +: ALU_CTRL_W];
                rsp_id_d = ID_W'(i);
            end
        end
    end
    alu u_alu (
        .in1_i   (sel.in1),
        .in2_i   (sel.in2),
        .op_i    (sel.op),
        .result_o(rsp_result_d),
        .zero_o  (rsp_zero_d)
    );
    // a new grant refills the slot even while the old response drains
    assign rsp_valid_d = |req_ready || (rsp_valid_q && !rsp_ready);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_result_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (|req_ready) begin
                rsp_id_q <= rsp_id_d;
                rsp_result_q <= rsp_result_d;
                rsp_zero_q <= rsp_zero_d;
            end
        end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero = rsp_zero_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus random traffic against a
// transaction-level model of arbitration, ALU and response slot.
module tb_alu_share_arbiter;
    localparam int N = 4;
    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*32-1:0] req_in1, req_in2;
    logic [N*4-1:0]  req_op;
    logic          rsp_valid, rsp_ready, rsp_zero;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_result;
    int            checks = 0, failures = 0;
    bit            m_valid, m_zero;
    int            m_id, m_ptr, last_g;
    logic [31:0]   m_res, saved;
    int            cnt [N];
    logic [3:0]    legal_ops [5] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4};

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit z);
        z = 0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h6: begin r = a - b; z = (a == b); end
            4'h4: r = a ^ b;
            default: r = 0;
        endcase
    endfunction

    function automatic int exp_grant();
        if (rst || (m_valid && !rsp_ready)) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic reset_model();
        m_valid = 0; m_zero = 0; m_id = 0; m_ptr = 0; m_res = 0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_valid[i] = 1'b1;
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
        req_op[4*i +: 4] = op;
    endtask

    task automatic rand_req(input int i);
        int sel;
        logic [31:0] a;
        sel = $urandom_range(0, 5);
        a = $urandom;
        set_req(i, a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                (sel == 5) ? 4'($urandom) : legal_ops[sel]);
    endtask

    task automatic step();
        int g;
        @(negedge clk);
        g = exp_grant();
        check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("rsp_valid", rsp_valid, m_valid);
        check("rsp_id", rsp_id, m_id);
        check("rsp_result", rsp_result, m_res);
        check("rsp_zero", rsp_zero, m_zero);
        @(posedge clk);
        if (g >= 0) begin
            ref_alu(req_op[4*g +: 4], req_in1[32*g +: 32], req_in2[32*g +: 32], m_res, m_zero);
            m_valid = 1; m_id = g; m_ptr = (g + 1) % N;
        end else if (rsp_ready) m_valid = 0;
        last_g = g;
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    initial begin
        rst = 1; rsp_ready = 1; req_valid = '0; req_in1 = '0; req_in2 = '0; req_op = '0;
        reset_model();
        repeat (2) @(posedge clk);
        set_req(0, 32'd5, 32'd3, 4'h2);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_result", rsp_result, 0);
        @(posedge clk); #1 rst = 0;
        step();
        check("single_valid", rsp_valid, 1);
        check("single_id", rsp_id, 0);
        check("single_res", rsp_result, 32'd8);
        check("single_zero", rsp_zero, 0);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 4'h2);
        step();
        check("wrap_grant", last_g, 1);
        check("wrap_res", rsp_result, 0);
        check("wrap_zero", rsp_zero, 0);
        for (int r = 0; r < 4; r++) begin
            if (!req_valid[0]) set_req(0, 32'd7, 32'd7, 4'h6);
            if (!req_valid[1]) set_req(1, 32'hF0F0_0000, 32'h0FF0_0000, 4'h4);
            step();
            check("rr_grant", last_g, r % 2);
            check("rr_id", rsp_id, r % 2);
            if (r % 2 == 0) check("rr_sub_zero", rsp_zero, 1);
            else check("rr_xor_res", rsp_result, 32'hFF00_0000);
        end
        set_req(1, 32'hF0F0_0000, 32'h0FF0_0000, 4'h4);
        rsp_ready = 0;
        saved = rsp_result;
        repeat (3) begin
            step();
            check("stall_grant", last_g, -1);
            check("stall_res", rsp_result, saved);
            check("stall_id", rsp_id, 1);
        end
        rsp_ready = 1;
        step();
        check("unstall_grant", last_g, 0);
        check("unstall_zero", rsp_zero, 1);
        step();
        check("drain1_grant", last_g, 1);
        set_req(0, $urandom, $urandom, 4'hF);
        step();
        check("illegal_grant", last_g, 0);
        check("illegal_res", rsp_result, 0);
        check("illegal_zero", rsp_zero, 0);
        set_req(2, 32'd10, 32'd20, 4'h2);
        step();
        check("pre_rst_grant", last_g, 2);
        rsp_ready = 0;
        step();
        check("pre_rst_valid", rsp_valid, 1);
        rst = 1;
        #1;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_res", rsp_result, 0);
        check("midrst_ready", req_ready, 0);
        reset_model();
        for (int i = 0; i < N; i++) rand_req(i);
        @(posedge clk); #1 rst = 0; rsp_ready = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) if (!req_valid[i]) rand_req(i);
            step();
            check("fair_grant", last_g, r % N);
            if (last_g >= 0) cnt[last_g]++;
        end
        for (int i = 0; i < N; i++) check("fair_count", cnt[i], 2);
        for (int c = 0; c < 400; c++) begin
            rsp_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
